// File: rtl/fetch_pipeline_controller.sv
// Fetch-stage sequencer for the 20-bit-instruction / 15-bit-PC core.
// Drives the PC enable and PC-mux select plus the F/D enable/flush and D/E
// flush controls from branch, load-use, imem-ready and halt events. It also
// runs a post-reset boot hold and a watchdog on instruction-memory stalls.
//
// Optional build macro FETCH_PERF_CNT_EN adds the saturating stall_cnt and
// flush_cnt performance counters. With the macro undefined, those ports and
// their logic are absent.
//
// Pipeline-control contract: every output is combinational from the current
// state and this cycle's inputs. A control is acted on at the next rising
// edge of clk. There is no back-pressure into this block.
module fetch_pipeline_controller #(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_src_e,
  input  logic             load_use_haz,
  input  logic             imem_ready,
  input  logic             halt_d,
  input  logic             resume,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_flush,
  output logic [2:0]       state_o,
  output logic             mem_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [2:0] S_BOOT     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_WAIT_MEM = 3'd2;
  localparam logic [2:0] S_HALT     = 3'd3;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  // Reject parameter values the counters cannot represent.
  if (BOOT_CYCLES < 1 || BOOT_CYCLES > 15) begin : g_bad_boot
    $error("BOOT_CYCLES out of range 1..15");
  end
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_tmo
    $error("MEM_TIMEOUT out of range 1..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  logic [2:0] state_q, state_d;
  logic [3:0] boot_q, boot_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] tmo_inc;
  logic       err_q, err_d;
  logic       redirect;

  assign tmo_inc = tmo_q + 8'd1;
  assign state_o = state_q;
  assign mem_err = err_q;

  // Next-state logic and pipeline controls. A branch taken in Execute beats
  // every younger event, so a wrong-path halt in Decode is squashed.
  always_comb begin
    state_d  = state_q;
    boot_d   = boot_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    redirect = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    fd_en    = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    case (state_q)
      S_BOOT: begin
        fd_en    = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        if (boot_q == BOOT_LAST) begin
          state_d = S_RUN;
          boot_d  = 4'd0;
        end else begin
          boot_d = boot_q + 4'd1;
        end
      end
      S_RUN, S_WAIT_MEM: begin
        if (pc_src_e) begin
          redirect = 1'b1;
          state_d  = S_RUN;
          tmo_d    = 8'd0;
        end else if (load_use_haz) begin
          // Hold PC and F/D, and insert a bubble into Execute. The memory
          // wait count is left as is because imem is not consulted here.
          de_flush = 1'b1;
        end else if (!imem_ready) begin
          // Keep the PC, and load a bubble into F/D until the fetch data is valid.
          fd_en    = 1'b1;
          fd_flush = 1'b1;
          if (tmo_inc == TMO_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_HALT;
            tmo_d   = 8'd0;
          end else begin
            state_d = S_WAIT_MEM;
            tmo_d   = tmo_inc;
          end
        end else if (halt_d) begin
          // The halt instruction stays in Decode, and bubbles flow into Execute.
          de_flush = 1'b1;
          state_d  = S_HALT;
          tmo_d    = 8'd0;
        end else begin
          pc_en   = 1'b1;
          fd_en   = 1'b1;
          state_d = S_RUN;
          tmo_d   = 8'd0;
        end
      end
      S_HALT: begin
        // A timeout halt is permanent, and even an older branch cannot restart fetch.
        if (pc_src_e && !err_q) begin
          redirect = 1'b1;
          state_d  = S_RUN;
        end else begin
          de_flush = 1'b1;
          if (resume && !err_q) begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        fd_flush = 1'b1;
        de_flush = 1'b1;
        state_d  = S_BOOT;
        boot_d   = 4'd0;
      end
    endcase
    if (redirect) begin
      pc_en    = 1'b1;
      pc_sel   = 1'b1;
      fd_en    = 1'b1;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end
    // While reset is held, every pipeline register is held or bubbled,
    // whatever the state register shows.
    if (!reset) begin
      pc_en    = 1'b0;
      pc_sel   = 1'b0;
      fd_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end
  end

  // State, boot counter, memory-wait counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      boot_q  <= 4'd0;
      tmo_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic             stall_ev;
  logic             redir_ev;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // A stall is any cycle in RUN or WAIT_MEM that holds the PC. pc_sel is
  // high only on a redirect.
  assign stall_ev = reset && !pc_en &&
                    (state_q == S_RUN || state_q == S_WAIT_MEM);
  assign redir_ev = pc_sel;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (redir_ev && flush_cnt_q != '1) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pipeline_controller.sv
// Self-checking bench for fetch_pipeline_controller (default parameters).
// Stimulus is driven 1 ns after the rising edge. Expected output vectors are
// queued at drive time and compared on the falling edge. When the build
// defines FETCH_PERF_CNT_EN, the performance counters are checked as well.
module tb_fetch_pipeline_controller;

  logic       clk;
  logic       reset;
  logic       pc_src_e;
  logic       load_use_haz;
  logic       imem_ready;
  logic       halt_d;
  logic       resume;
  logic       pc_en;
  logic       pc_sel;
  logic       fd_en;
  logic       fd_flush;
  logic       de_flush;
  logic [2:0] state_o;
  logic       mem_err;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  localparam logic [2:0] ST_BOOT = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HALT = 3'd3;
  localparam int         TMO     = 15;

  // Control bits are {pc_en, pc_sel, fd_en, fd_flush, de_flush}.
  localparam logic [4:0] C_RST   = 5'b00011;
  localparam logic [4:0] C_BOOT  = 5'b00111;
  localparam logic [4:0] C_RUN   = 5'b10100;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_STALL = 5'b00001;
  localparam logic [4:0] C_MEMW  = 5'b00110;
  localparam logic [4:0] C_HALT  = 5'b00001;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  fetch_pipeline_controller dut (
    .clk          (clk),
    .reset        (reset),
    .pc_src_e     (pc_src_e),
    .load_use_haz (load_use_haz),
    .imem_ready   (imem_ready),
    .halt_d       (halt_d),
    .resume       (resume),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .fd_en        (fd_en),
    .fd_flush     (fd_flush),
    .de_flush     (de_flush),
    .state_o      (state_o),
    .mem_err      (mem_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ev(input logic [2:0] s, input logic me, input logic [4:0] c);
    return {s, me, c};
  endfunction

  // Drivers.
  task automatic step(input logic rst, input logic ps, input logic lu, input logic rdy,
                      input logic hd, input logic rs, input logic [8:0] e, input string tag);
    @(posedge clk);
    #1;
    reset        = rst;
    pc_src_e     = ps;
    load_use_haz = lu;
    imem_ready   = rdy;
    halt_d       = hd;
    resume       = rs;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input logic [8:0] e, input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e, tag);
  endtask

  task automatic noisy(input logic rst, input logic [8:0] e, input string tag);
    step(rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, tag);
  endtask

  task automatic boot_seq();
    noisy(1'b1, ev(ST_BOOT, 1'b0, C_BOOT), "boot0");
    noisy(1'b1, ev(ST_BOOT, 1'b0, C_BOOT), "boot1");
    idle(ev(ST_RUN, 1'b0, C_RUN), "boot_done");
  endtask

  task automatic mem_burst(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           ev((i == 0) ? ST_RUN : ST_WAIT, 1'b0, C_MEMW), tag);
    end
  endtask

  // Scoreboard: compare each queued expectation on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    string      t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_vec(t, {state_o, mem_err, pc_en, pc_sel, fd_en, fd_flush, de_flush}, e);
    end
  end

  initial begin
    reset        = 1'b0;
    pc_src_e     = 1'b0;
    load_use_haz = 1'b0;
    imem_ready   = 1'b1;
    halt_d       = 1'b0;
    resume       = 1'b0;

    for (int i = 0; i < 3; i++) noisy(1'b0, ev(ST_BOOT, 1'b0, C_RST), "reset");
    boot_seq();
    idle(ev(ST_RUN, 1'b0, C_RUN), "run");

    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ev(ST_RUN, 1'b0, C_STALL), "load_use");
    idle(ev(ST_RUN, 1'b0, C_RUN), "load_use_after");

    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ev(ST_RUN, 1'b0, C_REDIR), "redir_prio");
    idle(ev(ST_RUN, 1'b0, C_RUN), "redir_after");

    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ev(ST_RUN, 1'b0, C_STALL), "halt_d");
    idle(ev(ST_HALT, 1'b0, C_HALT), "halt");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ev(ST_HALT, 1'b0, C_HALT), "resume");
    idle(ev(ST_RUN, 1'b0, C_RUN), "resume_run");

    // Two bursts just below the limit, each closed by a ready cycle, must not time out.
    mem_burst(TMO - 1, "mem_wait_a");
    idle(ev(ST_WAIT, 1'b0, C_RUN), "mem_ready_a");
    mem_burst(TMO - 1, "mem_wait_b");
    idle(ev(ST_WAIT, 1'b0, C_RUN), "mem_ready_b");
    for (int k = 0; k < 3; k++) begin
      mem_burst($urandom_range(1, TMO - 1), "mem_wait_rnd");
      idle(ev(ST_WAIT, 1'b0, C_RUN), "mem_ready_rnd");
      idle(ev(ST_RUN, 1'b0, C_RUN), "run_rnd");
    end

    mem_burst(2, "redir_wait_pre");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ev(ST_WAIT, 1'b0, C_REDIR), "redir_wait");
    idle(ev(ST_RUN, 1'b0, C_RUN), "redir_wait_after");

    mem_burst(1, "lu_wait_pre");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ev(ST_WAIT, 1'b0, C_STALL), "lu_wait");
    idle(ev(ST_WAIT, 1'b0, C_RUN), "lu_wait_ready");

    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ev(ST_RUN, 1'b0, C_STALL), "halt_d2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ev(ST_HALT, 1'b0, C_REDIR), "redir_halt");
    idle(ev(ST_RUN, 1'b0, C_RUN), "redir_halt_after");

    mem_burst(TMO, "timeout_cnt");
    idle(ev(ST_HALT, 1'b1, C_HALT), "mem_err");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ev(ST_HALT, 1'b1, C_HALT), "resume_err");
    idle(ev(ST_HALT, 1'b1, C_HALT), "halt_sticky");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ev(ST_HALT, 1'b1, C_HALT), "resume_err2");
    idle(ev(ST_HALT, 1'b1, C_HALT), "halt_sticky2");

    noisy(1'b0, ev(ST_BOOT, 1'b0, C_RST), "reset_halt");
    boot_seq();

    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ev(ST_RUN, 1'b0, C_STALL), "pre_reset_stall");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ev(ST_BOOT, 1'b0, C_RST), "reset_stall");
`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    #1;
    check_vec("stall_cnt_rst", stall_cnt, 0);
    check_vec("flush_cnt_rst", flush_cnt, 0);
`endif
    boot_seq();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ev(ST_RUN, 1'b0, C_STALL), "perf_lu");
      idle(ev(ST_RUN, 1'b0, C_RUN), "perf_run");
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ev(ST_RUN, 1'b0, C_REDIR), "perf_redir");
    end
    idle(ev(ST_RUN, 1'b0, C_RUN), "perf_end");
`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    #1;
    check_vec("stall_cnt", stall_cnt, 3);
    check_vec("flush_cnt", flush_cnt, 2);
`endif

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
